// File: rtl/fetch1_if.sv
// fetch1_if -- instruction-line bus between the fetch stage and memory.
//
// Signals:
//   bus_req        fetch -> mem   line read request, held until bus_reqack
//   bus_reqaddr    fetch -> mem   8-byte-aligned line address
//   bus_reqack     mem -> fetch   request accepted
//   bus_resp       mem -> fetch   returned line ([31:0] at addr+0, [63:32] at addr+4)
//   bus_respvalid  mem -> fetch   bus_resp valid, single beat
//
// Modports: master (fetch side), slave (memory side).
interface fetch1_if #(
  parameter int BUS_DATA_WIDTH = 64
);
  logic                      bus_req;
  logic [BUS_DATA_WIDTH-1:0] bus_reqaddr;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic                      bus_respvalid;

  modport master (
    output bus_req,
    output bus_reqaddr,
    input  bus_reqack,
    input  bus_resp,
    input  bus_respvalid
  );

  modport slave (
    input  bus_req,
    input  bus_reqaddr,
    output bus_reqack,
    output bus_resp,
    output bus_respvalid
  );
endinterface

// File: rtl/fetch1.sv
// fetch1 -- instruction fetch stage with a single-line instruction buffer.
//
// The stage keeps one 8-byte line. While the fetch PC hits in that line it
// hands one 32-bit instruction per cycle to decode. On a miss it requests the
// line over the bus, waits for the single-beat response, fills the buffer and
// re-evaluates the hit. Branch redirects replace the PC at any time but never
// abort a bus transaction in flight.
//
// Ports:
//   clk             clock, all state updates on its rising edge
//   reset           asynchronous, active-high reset
//   inStall         decode cannot accept; current outputs are held
//   inPCSrc         branch taken; redirect fetch to inBranchTarget
//   inBranchTarget  redirect PC (low two bits ignored)
//   bus             fetch1_if.master, instruction-line bus
//   outPc           PC of outIns
//   outIns          fetched instruction
//   outDecodeEn     outPc/outIns valid for decode
module fetch1 #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = 64'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inStall,
  input  logic                      inPCSrc,
  input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
  fetch1_if.master                  bus,
  output logic [BUS_DATA_WIDTH-1:0] outPc,
  output logic [31:0]               outIns,
  output logic                      outDecodeEn
);
  localparam int W = BUS_DATA_WIDTH;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   pc;
  logic [W-1:0]   lineData;
  logic [W-1:3]   lineAddr;
  logic           lineValid;
  logic [W-1:3]   reqAddr;

  logic           hit;
  logic           slotFree;
  logic [W-1:0]   redirectPc;
  logic           unusedTargetLow;

  assign hit             = lineValid && (lineAddr == pc[W-1:3]);
  // Decode either has nothing from us or is taking what we hold this cycle.
  assign slotFree        = !outDecodeEn || !inStall;
  assign redirectPc      = {inBranchTarget[W-1:2], 2'b00};
  assign unusedTargetLow = ^inBranchTarget[1:0];

  // Fetch FSM, line buffer, bus request registers and decode-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      lineData        <= '0;
      lineAddr        <= '0;
      lineValid       <= 1'b0;
      reqAddr         <= '0;
      bus.bus_req     <= 1'b0;
      bus.bus_reqaddr <= '0;
      outDecodeEn     <= 1'b0;
      outPc           <= '0;
      outIns          <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          // A redirect makes the current pc stale: neither deliver nor
          // request for it, just re-evaluate next cycle at the new pc.
          if (!inPCSrc) begin
            if (hit) begin
              if (slotFree) begin
                outIns      <= pc[2] ? lineData[63:32] : lineData[31:0];
                outPc       <= pc;
                outDecodeEn <= 1'b1;
                pc          <= pc + W'(3'd4);
              end
            end else begin
              reqAddr         <= pc[W-1:3];
              bus.bus_req     <= 1'b1;
              bus.bus_reqaddr <= {pc[W-1:3], 3'b000};
              state           <= REQ;
              if (slotFree) begin
                outDecodeEn <= 1'b0;
              end
            end
          end
        end
        REQ: begin
          if (bus.bus_reqack) begin
            bus.bus_req <= 1'b0;
            state       <= WAIT;
          end
          // A stalled instruction left over from before the miss is retired
          // as soon as decode takes it.
          if (slotFree) begin
            outDecodeEn <= 1'b0;
          end
        end
        WAIT: begin
          // The fill uses the address this transaction was issued for, even
          // if the pc has since been redirected elsewhere.
          if (bus.bus_respvalid) begin
            lineData  <= bus.bus_resp;
            lineAddr  <= reqAddr;
            lineValid <= 1'b1;
            state     <= FETCH;
          end
          if (slotFree) begin
            outDecodeEn <= 1'b0;
          end
        end
        default: begin
          state       <= FETCH;
          bus.bus_req <= 1'b0;
          outDecodeEn <= 1'b0;
        end
      endcase

      // Redirect wins over stall and over any delivery chosen above.
      if (inPCSrc) begin
        pc          <= redirectPc;
        outDecodeEn <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch1.sv
module tb_fetch1;
  logic        clk = 1'b0;
  logic        reset;
  logic        inStall;
  logic        inPCSrc;
  logic [63:0] inBranchTarget;
  logic [63:0] outPc;
  logic [31:0] outIns;
  logic        outDecodeEn;

  logic        wReset;
  logic        wStall;
  logic        wPCSrc;
  logic [63:0] wTarget;
  logic [63:0] wOutPc;
  logic [31:0] wOutIns;
  logic        wOutDecodeEn;

  int total = 0;
  int bad   = 0;

  fetch1_if #(.BUS_DATA_WIDTH(64)) busIf ();
  fetch1_if #(.BUS_DATA_WIDTH(64)) wBusIf ();

  fetch1 #(.BUS_DATA_WIDTH(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .inStall(inStall), .inPCSrc(inPCSrc),
    .inBranchTarget(inBranchTarget), .bus(busIf.master),
    .outPc(outPc), .outIns(outIns), .outDecodeEn(outDecodeEn)
  );

  fetch1 #(.BUS_DATA_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutWrap (
    .clk(clk), .reset(wReset), .inStall(wStall), .inPCSrc(wPCSrc),
    .inBranchTarget(wTarget), .bus(wBusIf.master),
    .outPc(wOutPc), .outIns(wOutIns), .outDecodeEn(wOutDecodeEn)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for a request, check its address, ack it, return one line.
  task automatic busServe(input logic [63:0] expAddr, input logic [63:0] data, input string nm);
    int waited = 0;
    while (busIf.bus_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (busIf.bus_req !== 1'b1) begin
      bad++;
      $display("FAIL %s_req: bus_req=%b after %0d cycles, required 1", nm, busIf.bus_req, waited);
    end
    total++;
    if (busIf.bus_reqaddr !== expAddr) begin
      bad++;
      $display("FAIL %s_addr: bus_reqaddr=%h required %h", nm, busIf.bus_reqaddr, expAddr);
    end
    busIf.bus_reqack = 1'b1;
    tick();
    busIf.bus_reqack    = 1'b0;
    busIf.bus_respvalid = 1'b1;
    busIf.bus_resp      = data;
    tick();
    busIf.bus_respvalid = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL rst_en: got %b required 0", outDecodeEn); end
    total++; if (outPc !== 64'h0) begin bad++; $display("FAIL rst_pc: got %h required 0", outPc); end
    total++; if (outIns !== 32'h0) begin bad++; $display("FAIL rst_ins: got %h required 0", outIns); end
    total++; if (busIf.bus_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b required 0", busIf.bus_req); end
    total++; if (busIf.bus_reqaddr !== 64'h0) begin bad++; $display("FAIL rst_addr: got %h required 0", busIf.bus_reqaddr); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_cold_fetch();
    busServe(64'h0, 64'h00500093_00100093, "cold");
    tick();
    total++; if (outDecodeEn !== 1'b1) begin bad++; $display("FAIL cold_en0: got %b required 1", outDecodeEn); end
    total++; if (outPc !== 64'h0) begin bad++; $display("FAIL cold_pc0: got %h required 0", outPc); end
    total++; if (outIns !== 32'h00100093) begin bad++; $display("FAIL cold_ins0: got %h required 00100093", outIns); end
    tick();
    total++; if (outDecodeEn !== 1'b1) begin bad++; $display("FAIL cold_en4: got %b required 1", outDecodeEn); end
    total++; if (outPc !== 64'h4) begin bad++; $display("FAIL cold_pc4: got %h required 4", outPc); end
    total++; if (outIns !== 32'h00500093) begin bad++; $display("FAIL cold_ins4: got %h required 00500093", outIns); end
    tick();
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL cold_en_miss: got %b required 0", outDecodeEn); end
    total++; if (busIf.bus_req !== 1'b1) begin bad++; $display("FAIL cold_req8: got %b required 1", busIf.bus_req); end
    total++; if (busIf.bus_reqaddr !== 64'h8) begin bad++; $display("FAIL cold_addr8: got %h required 8", busIf.bus_reqaddr); end
  endtask

  task automatic test_redirect_wait();
    busIf.bus_reqack = 1'b1;
    tick();
    busIf.bus_reqack = 1'b0;
    inPCSrc        = 1'b1;
    inBranchTarget = 64'h1004;
    tick();
    inPCSrc = 1'b0;
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL redir_en: got %b required 0", outDecodeEn); end
    busIf.bus_respvalid = 1'b1;
    busIf.bus_resp      = 64'h11111111_22222222;
    tick();
    busIf.bus_respvalid = 1'b0;
    tick();
    total++; if (busIf.bus_req !== 1'b1) begin bad++; $display("FAIL redir_req: got %b required 1", busIf.bus_req); end
    total++; if (busIf.bus_reqaddr !== 64'h1000) begin bad++; $display("FAIL redir_addr: got %h required 1000", busIf.bus_reqaddr); end
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL redir_en_req: got %b required 0", outDecodeEn); end
    busServe(64'h1000, 64'hAAAA0001_BBBB0002, "redir");
    tick();
    total++; if (outDecodeEn !== 1'b1) begin bad++; $display("FAIL redir_en1: got %b required 1", outDecodeEn); end
    total++; if (outPc !== 64'h1004) begin bad++; $display("FAIL redir_pc: got %h required 1004", outPc); end
    total++; if (outIns !== 32'hAAAA0001) begin bad++; $display("FAIL redir_ins: got %h required AAAA0001", outIns); end
    // Back to the lower half of the buffered line: must hit with no request.
    inPCSrc        = 1'b1;
    inBranchTarget = 64'h1000;
    tick();
    inPCSrc = 1'b0;
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL rehit_en0: got %b required 0", outDecodeEn); end
    tick();
    total++; if (outDecodeEn !== 1'b1) begin bad++; $display("FAIL rehit_en1: got %b required 1", outDecodeEn); end
    total++; if (outPc !== 64'h1000) begin bad++; $display("FAIL rehit_pc: got %h required 1000", outPc); end
    total++; if (outIns !== 32'hBBBB0002) begin bad++; $display("FAIL rehit_ins: got %h required BBBB0002", outIns); end
    total++; if (busIf.bus_req !== 1'b0) begin bad++; $display("FAIL rehit_req: got %b required 0", busIf.bus_req); end
  endtask

  task automatic test_stall();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busServe(64'h0, 64'h00500093_00100093, "stall");
    inStall = 1'b1;
    tick();
    total++; if (outDecodeEn !== 1'b1 || outPc !== 64'h0) begin bad++; $display("FAIL stall_first: en=%b pc=%h required 1/0", outDecodeEn, outPc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outDecodeEn !== 1'b1 || outPc !== 64'h0 || outIns !== 32'h00100093) begin
        bad++;
        $display("FAIL stall_hold%0d: en=%b pc=%h ins=%h required 1/0/00100093", i, outDecodeEn, outPc, outIns);
      end
    end
    inStall = 1'b0;
    tick();
    total++; if (outPc !== 64'h4) begin bad++; $display("FAIL stall_release_pc: got %h required 4", outPc); end
    total++; if (outIns !== 32'h00500093) begin bad++; $display("FAIL stall_release_ins: got %h required 00500093", outIns); end
  endtask

  task automatic test_redirect_stall();
    inStall        = 1'b1;
    inPCSrc        = 1'b1;
    inBranchTarget = 64'h2002;
    tick();
    inStall = 1'b0;
    inPCSrc = 1'b0;
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL rstall_en: got %b required 0", outDecodeEn); end
    busServe(64'h2000, 64'hCAFE0001_D00D0002, "rstall");
    tick();
    total++; if (outPc !== 64'h2000) begin bad++; $display("FAIL rstall_pc: got %h required 2000", outPc); end
    total++; if (outIns !== 32'hD00D0002) begin bad++; $display("FAIL rstall_ins: got %h required D00D0002", outIns); end
  endtask

  task automatic test_reset_wait();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    busIf.bus_reqack = 1'b1;
    tick();
    busIf.bus_reqack = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (busIf.bus_req !== 1'b0 || outDecodeEn !== 1'b0) begin bad++; $display("FAIL rwait_async: req=%b en=%b required 0/0", busIf.bus_req, outDecodeEn); end
    tick();
    reset = 1'b0;
    busIf.bus_respvalid = 1'b1;
    busIf.bus_resp      = 64'hDEADDEAD_DEADDEAD;
    tick();
    total++; if (busIf.bus_req !== 1'b1 || busIf.bus_reqaddr !== 64'h0) begin bad++; $display("FAIL rwait_newreq: req=%b addr=%h required 1/0", busIf.bus_req, busIf.bus_reqaddr); end
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL rwait_en_a: got %b required 0", outDecodeEn); end
    tick();
    busIf.bus_respvalid = 1'b0;
    total++; if (outDecodeEn !== 1'b0) begin bad++; $display("FAIL rwait_en_b: got %b required 0", outDecodeEn); end
    busServe(64'h0, 64'h0000000B_0000000A, "rwait");
    tick();
    total++; if (outDecodeEn !== 1'b1 || outIns !== 32'h0000000A) begin bad++; $display("FAIL rwait_ins: en=%b ins=%h required 1/0000000A", outDecodeEn, outIns); end
  endtask

  task automatic test_wrap();
    int waited = 0;
    wReset = 1'b0;
    while (wBusIf.bus_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++; if (wBusIf.bus_reqaddr !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL wrap_addr0: got %h required FFFFFFFFFFFFFFF8", wBusIf.bus_reqaddr); end
    wBusIf.bus_reqack = 1'b1;
    tick();
    wBusIf.bus_reqack    = 1'b0;
    wBusIf.bus_respvalid = 1'b1;
    wBusIf.bus_resp      = 64'h00000077_00000066;
    tick();
    wBusIf.bus_respvalid = 1'b0;
    tick();
    total++; if (wOutPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %h required FFFFFFFFFFFFFFFC", wOutPc); end
    total++; if (wOutIns !== 32'h00000077 || wOutDecodeEn !== 1'b1) begin bad++; $display("FAIL wrap_ins: ins=%h en=%b required 00000077/1", wOutIns, wOutDecodeEn); end
    tick();
    total++; if (wBusIf.bus_req !== 1'b1 || wBusIf.bus_reqaddr !== 64'h0) begin bad++; $display("FAIL wrap_req0: req=%b addr=%h required 1/0", wBusIf.bus_req, wBusIf.bus_reqaddr); end
    total++; if (wOutDecodeEn !== 1'b0) begin bad++; $display("FAIL wrap_en: got %b required 0", wOutDecodeEn); end
  endtask

  initial begin
    reset = 1'b0;
    inStall = 1'b0;
    inPCSrc = 1'b0;
    inBranchTarget = 64'h0;
    busIf.bus_reqack = 1'b0;
    busIf.bus_resp = 64'h0;
    busIf.bus_respvalid = 1'b0;
    wReset = 1'b1;
    wStall = 1'b0;
    wPCSrc = 1'b0;
    wTarget = 64'h0;
    wBusIf.bus_reqack = 1'b0;
    wBusIf.bus_resp = 64'h0;
    wBusIf.bus_respvalid = 1'b0;

    test_reset();
    test_cold_fetch();
    test_redirect_wait();
    test_stall();
    test_redirect_stall();
    test_reset_wait();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fetch1.md
FETCH1 -- requirements
Module: fetch1

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, sets the width of PCs, addresses and the bus data path.
REQ-002 Parameter RESET_PC, default 64'h0, is the PC loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inStall  input  1  decode cannot accept; hold current outputs.
REQ-006 inPCSrc  input  1  branch taken; redirect fetch.
REQ-007 inBranchTarget  input  64  redirect PC.
REQ-008 bus_req  output  1  instruction-line read request.
REQ-009 bus_reqaddr  output  64  8-byte-aligned line address.
REQ-010 bus_reqack  input  1  request accepted.
REQ-011 bus_resp  input  64  returned line; bits [31:0] are the instruction at addr+0, bits [63:32] at addr+4.
REQ-012 bus_respvalid  input  1  bus_resp valid; single beat.
REQ-013 outPc  output  64  PC of outIns.
REQ-014 outIns  output  32  fetched instruction.
REQ-015 outDecodeEn  output  1  outPc/outIns valid for decode.

Function
REQ-016 Internal state: fetch PC, plus a one-line buffer (lineData[63:0], lineAddr[63:3], lineValid) and reqAddr[63:3].
REQ-017 FSM states are FETCH, REQ and WAIT.
REQ-018 Hit = lineValid && lineAddr == pc[63:3].
REQ-019 Output slot is free when !outDecodeEn || !inStall.
REQ-020 FETCH, hit, slot free: outIns <= pc[2] ? lineData[63:32] : lineData[31:0]; outPc <= pc; outDecodeEn <= 1; pc <= pc+4.
REQ-021 FETCH, hit, slot not free: outputs and pc held.
REQ-022 FETCH, miss: reqAddr <= pc[63:3]; go to REQ; if slot free, outDecodeEn <= 0.
REQ-023 REQ: bus_req = 1 and bus_reqaddr = {reqAddr, 3'b000}, both registered and stable until bus_reqack.
REQ-024 REQ, bus_reqack = 1: bus_req <= 0; go to WAIT.
REQ-025 WAIT, bus_respvalid = 1: lineData <= bus_resp; lineAddr <= reqAddr; lineValid <= 1; go to FETCH.
REQ-026 bus_respvalid outside WAIT is ignored.
REQ-027 Miss latency: respvalid in cycle N gives outDecodeEn = 1 in cycle N+2.
REQ-028 Hit throughput: one instruction per cycle.
REQ-029 Redirect (inPCSrc = 1), any state: pc <= {inBranchTarget[63:2], 2'b00}; outDecodeEn <= 0 next cycle.
REQ-030 A redirect overrides inStall and any delivery in the same cycle.
REQ-031 A redirect does not abort an in-flight REQ or WAIT: the transaction completes and fills the buffer with its own address. FETCH then re-evaluates hit against the new pc.
REQ-032 A redirect in the same cycle as bus_respvalid still fills the buffer; no instruction is delivered that cycle.
REQ-033 pc+4 wraps modulo 2^64.
REQ-034 While outDecodeEn = 1 and inStall = 1, outPc and outIns are bit-stable.
REQ-035 lineValid and lineData are unaffected by stalls and redirects.

Reset
REQ-036 On reset assertion (asynchronous), immediately: pc = RESET_PC; state = FETCH; lineValid = 0; bus_req = 0; bus_reqaddr = 0; outDecodeEn = 0; outPc = 0; outIns = 0.
REQ-037 Reset mid-transaction abandons it; a later bus_respvalid is ignored.
REQ-038 The first request is issued the cycle after reset deasserts (FETCH detects miss, REQ the next cycle).

Verification
REQ-039 Cold fetch: reset -> bus_req with addr 0; ack; resp 64'h00500093_00100093 -> outIns 00100093 / outPc 0, then 00500093 / outPc 4 on consecutive cycles, then bus_req with addr 8.
REQ-040 Stall: inStall held 3 cycles while outDecodeEn = 1 at outPc 0 -> outputs frozen; outPc 4 appears the cycle after inStall drops.
REQ-041 Redirect in WAIT: target 0x1004 while fetching line 8 -> outDecodeEn 0; line 8 fills; next bus_reqaddr 0x1000; first delivery outPc 0x1004 from resp[63:32].
REQ-042 Redirect and stall together -> outDecodeEn 0 next cycle; pc = target.
REQ-043 Reset during WAIT, respvalid 2 cycles later -> no fill, outDecodeEn stays 0, new request to RESET_PC.
REQ-044 Wrap: RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> after delivery, pc = 0 and bus_reqaddr = 0.
